mem2_stage: RTL and testbench
=============================

MEM2_STAGE -- requirements
Module: mem2_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port stall  input  7 (`StallBus)  pipeline stall vector; bits [5] and [6] are used.
REQ-004 SHALL have port mem12mem2_bus  input  106  fields {pc[105:74], ld_op[73:71], ld_en[70], rf_we[69], rf_waddr[68:64], ex_result[63:32], sram_rdata[31:0]}.
REQ-005 SHALL have port mem22wb_bus  output  70  fields {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
REQ-006 SHALL have port mem2_fwd_bus  output  38  fields {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}, forwarded to decode.
REQ-007 SHALL have port ld_misalign  output  1  the current stage holds a misaligned load.
REQ-008 SHALL have port ld_count  output  32  count of loads retired from this stage.

Function
REQ-009 SHALL latch mem12mem2_bus into a 106-bit stage register on each clk edge when stall[5]=0.
REQ-010 SHALL clear the stage register to all-zero (bubble) when stall[5]=1 and stall[6]=0.
REQ-011 SHALL hold the stage register unchanged when stall[5]=1 and stall[6]=1.
REQ-012 SHALL drive all outputs combinationally from the stage register and ld_count, with one-cycle latency from the input bus to the outputs.
REQ-013 SHALL use byte offset a = ex_result[1:0] and ld_op encoding 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-014 SHALL produce LB/LBU data from byte sram_rdata[8a+7:8a], sign-extended (LB) or zero-extended (LBU) to 32 bits.
REQ-015 SHALL produce LH/LHU data from sram_rdata[31:16] when a[1]=1 and from [15:0] otherwise, sign-extended (LH) or zero-extended (LHU).
REQ-016 SHALL produce LW data as sram_rdata unchanged.
REQ-017 SHALL set rf_wdata to the extracted load data when ld_en=1, and to ex_result otherwise.
REQ-018 SHALL assert ld_misalign when ld_en=1 and either LH/LHU has a[0]=1 or LW has a!=0.
REQ-019 SHALL force output rf_we to 0 on both output buses while ld_misalign=1.
REQ-020 SHALL treat an undefined ld_op (011, 110, 111) with ld_en=1 as LW for the data path and SHALL NOT flag misalignment for it.
REQ-021 SHALL increment ld_count by 1 on a clk edge when the stage holds ld_en=1, ld_misalign=0 and stall[5]=0.
REQ-022 SHALL wrap ld_count from 0xFFFF_FFFF to 0.
REQ-023 SHALL keep mem2_fwd_bus identical to the corresponding mem22wb_bus fields in every cycle.

Reset
REQ-024 SHALL clear the stage register and ld_count to 0 when rst_n=0 at a clk edge; reset SHALL take priority over stall.
REQ-025 SHALL drive mem22wb_bus=0, mem2_fwd_bus=0, ld_misalign=0 and ld_count=0 during and after reset until the first non-bubble capture.
REQ-026 SHALL discard an in-flight instruction on reset without incrementing ld_count.

Verification
REQ-027 SHALL cover LB at a=3 with rdata=0x80FF_1234 -> rf_wdata=0xFFFF_FF80 and rf_we passed through, one cycle after capture.
REQ-028 SHALL cover LHU at a=2 with rdata=0x8001_7FFF -> rf_wdata=0x0000_8001; LH at a=1 -> ld_misalign=1 and rf_we=0.
REQ-029 SHALL cover a non-load with ex_result=0x1234_5678 and rf_waddr=7 -> mem22wb rf_wdata=0x1234_5678, fwd bus equal, ld_count unchanged.
REQ-030 SHALL cover stall[6:5]=01 -> next-cycle outputs all zero; stall[6:5]=11 -> outputs held for each stalled cycle and ld_count frozen.
REQ-031 SHALL cover ld_count preloaded near 0xFFFF_FFFF via a load stream -> the count wraps to 0; rst_n=0 mid-stream -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/mem2_stage_if.sv
// Bus bundle between the MEM1 and MEM2 pipeline stages and their downstream consumers.
// The master drives the stall vector and the MEM1 bus; the slave (mem2_stage) drives the results.
interface mem2_stage_if;
   logic [6:0]   stall;
   logic [105:0] mem12mem2_bus;
   logic [69:0]  mem22wb_bus;
   logic [37:0]  mem2_fwd_bus;
   logic         ld_misalign;
   logic [31:0]  ld_count;

   modport master (
      output stall,
      output mem12mem2_bus,
      input  mem22wb_bus,
      input  mem2_fwd_bus,
      input  ld_misalign,
      input  ld_count
   );

   modport slave (
      input  stall,
      input  mem12mem2_bus,
      output mem22wb_bus,
      output mem2_fwd_bus,
      output ld_misalign,
      output ld_count
   );
endinterface

// File: rtl/mem2_stage.sv
// Second memory pipeline stage: captures the MEM1 bus, aligns and extends load data,
// flags misaligned loads and counts retired loads.
module mem2_stage (
   input  logic        clk,
   input  logic        rst_n,
   mem2_stage_if.slave bus
);

   logic [105:0] stage_r;
   logic [31:0]  ld_count_r;

   logic [31:0]  pc_s;
   logic [2:0]   ld_op_s;
   logic         ld_en_s;
   logic         rf_we_s;
   logic [4:0]   rf_waddr_s;
   logic [31:0]  ex_result_s;
   logic [31:0]  sram_rdata_s;
   logic [1:0]   byte_off_s;
   logic         misalign_s;
   logic         rf_we_out_s;
   logic [31:0]  rf_wdata_s;

   // Undefined ld_op encodings fall through to the word path.
   function automatic logic [31:0] load_data(input logic [2:0]  op,
                                             input logic [1:0]  a,
                                             input logic [31:0] rdata);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] data_v;
      case (a)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = a[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         3'b000:  data_v = {{24{byte_v[7]}}, byte_v};
         3'b100:  data_v = {24'd0, byte_v};
         3'b001:  data_v = {{16{half_v[15]}}, half_v};
         3'b101:  data_v = {16'd0, half_v};
         default: data_v = rdata;
      endcase
      return data_v;
   endfunction

   assign pc_s         = stage_r[105:74];
   assign ld_op_s      = stage_r[73:71];
   assign ld_en_s      = stage_r[70];
   assign rf_we_s      = stage_r[69];
   assign rf_waddr_s   = stage_r[68:64];
   assign ex_result_s  = stage_r[63:32];
   assign sram_rdata_s = stage_r[31:0];
   assign byte_off_s   = ex_result_s[1:0];

   // Stage register: capture, bubble on stall[5] alone, hold when stall[6] also set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_r <= 106'd0;
      end else if (!bus.stall[5]) begin
         stage_r <= bus.mem12mem2_bus;
      end else if (!bus.stall[6]) begin
         stage_r <= 106'd0;
      end else begin
         stage_r <= stage_r;
      end
   end

   // Retired-load counter; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ld_count_r <= 32'd0;
      end else if (ld_en_s && !misalign_s && !bus.stall[5]) begin
         ld_count_r <= ld_count_r + 32'd1;
      end else begin
         ld_count_r <= ld_count_r;
      end
   end

   // Misalignment detection and write-back data selection.
   always_comb begin
      misalign_s = 1'b0;
      rf_wdata_s = ex_result_s;
      if (ld_en_s) begin
         rf_wdata_s = load_data(ld_op_s, byte_off_s, sram_rdata_s);
         case (ld_op_s)
            3'b001, 3'b101: misalign_s = byte_off_s[0];
            3'b010:         misalign_s = (byte_off_s != 2'd0);
            default:        misalign_s = 1'b0;
         endcase
      end else begin
         rf_wdata_s = ex_result_s;
      end
      rf_we_out_s = rf_we_s & ~misalign_s;
   end

   assign bus.mem22wb_bus  = {pc_s, rf_we_out_s, rf_waddr_s, rf_wdata_s};
   assign bus.mem2_fwd_bus = {rf_we_out_s, rf_waddr_s, rf_wdata_s};
   assign bus.ld_misalign  = misalign_s;
   assign bus.ld_count     = ld_count_r;

endmodule

// File: tb/tb_mem2_stage.sv
// Directed testbench for mem2_stage: hand-computed vectors covering load extension,
// misalignment, stalls, counter wrap and mid-stream reset.
module tb_mem2_stage;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miscmp;

   mem2_stage_if bus_if ();

   mem2_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] ST_RUN    = 7'b0000000;
   localparam logic [6:0] ST_BUBBLE = 7'b0100000;
   localparam logic [6:0] ST_HOLD   = 7'b1100000;

   function automatic logic [105:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                       input logic en, input logic we, input logic [4:0] waddr,
                                       input logic [31:0] exr, input logic [31:0] rdata);
      return {pc, op, en, we, waddr, exr, rdata};
   endfunction

   function automatic logic [69:0] wb(input logic [31:0] pc, input logic we,
                                      input logic [4:0] waddr, input logic [31:0] data);
      return {pc, we, waddr, data};
   endfunction

   task automatic check_vec(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_miscmp = n_miscmp + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one vector, clock it in, then compare every output a little after the edge.
   task automatic apply(input string tag, input logic [6:0] st, input logic [105:0] in,
                        input logic [69:0] exp_wb, input logic exp_mis, input logic [31:0] exp_cnt);
      bus_if.stall         = st;
      bus_if.mem12mem2_bus = in;
      @(posedge clk);
      #1;
      check_vec({tag, ".wb"},  70'(bus_if.mem22wb_bus),  exp_wb);
      check_vec({tag, ".fwd"}, 70'(bus_if.mem2_fwd_bus), 70'(exp_wb[37:0]));
      check_vec({tag, ".mis"}, 70'(bus_if.ld_misalign), 70'(exp_mis));
      check_vec({tag, ".cnt"}, 70'(bus_if.ld_count),    70'(exp_cnt));
   endtask

   initial begin
      n_vec    = 0;
      n_miscmp = 0;

      // Reset beats a concurrent hold stall and a busy input bus.
      rst_n = 1'b0;
      apply("rst0", ST_HOLD, mk(32'hDEAD_0000, 3'b010, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            70'd0, 1'b0, 32'd0);
      apply("rst1", ST_RUN,  mk(32'hDEAD_0004, 3'b000, 1'b1, 1'b1, 5'd30, 32'h0000_0003, 32'h8000_0000),
            70'd0, 1'b0, 32'd0);
      rst_n = 1'b1;

      apply("lb_a3",   ST_RUN, mk(32'h100, 3'b000, 1'b1, 1'b1, 5'd3,  32'h0000_1003, 32'h80FF_1234),
            wb(32'h100, 1'b1, 5'd3,  32'hFFFF_FF80), 1'b0, 32'd0);
      apply("lhu_a2",  ST_RUN, mk(32'h104, 3'b101, 1'b1, 1'b1, 5'd4,  32'h0000_2002, 32'h8001_7FFF),
            wb(32'h104, 1'b1, 5'd4,  32'h0000_8001), 1'b0, 32'd1);
      apply("lh_a1",   ST_RUN, mk(32'h108, 3'b001, 1'b1, 1'b1, 5'd5,  32'h0000_3001, 32'h8001_7FFF),
            wb(32'h108, 1'b0, 5'd5,  32'h0000_7FFF), 1'b1, 32'd2);
      apply("nonload", ST_RUN, mk(32'h10C, 3'b000, 1'b0, 1'b1, 5'd7,  32'h1234_5678, 32'hDEAD_BEEF),
            wb(32'h10C, 1'b1, 5'd7,  32'h1234_5678), 1'b0, 32'd2);
      apply("undef",   ST_RUN, mk(32'h110, 3'b011, 1'b1, 1'b1, 5'd9,  32'h0000_4002, 32'hCAFE_F00D),
            wb(32'h110, 1'b1, 5'd9,  32'hCAFE_F00D), 1'b0, 32'd2);
      apply("lw_a0",   ST_RUN, mk(32'h114, 3'b010, 1'b1, 1'b1, 5'd10, 32'h0000_5000, 32'h1122_3344),
            wb(32'h114, 1'b1, 5'd10, 32'h1122_3344), 1'b0, 32'd3);
      apply("lbu_a1",  ST_RUN, mk(32'h118, 3'b100, 1'b1, 1'b1, 5'd11, 32'h0000_6001, 32'h1234_80FF),
            wb(32'h118, 1'b1, 5'd11, 32'h0000_0080), 1'b0, 32'd4);
      apply("lw_a2",   ST_RUN, mk(32'h11C, 3'b010, 1'b1, 1'b1, 5'd12, 32'h0000_7002, 32'h55AA_55AA),
            wb(32'h11C, 1'b0, 5'd12, 32'h55AA_55AA), 1'b1, 32'd5);
      apply("lb_a0",   ST_RUN, mk(32'h120, 3'b000, 1'b1, 1'b1, 5'd13, 32'h0000_8000, 32'h0000_007F),
            wb(32'h120, 1'b1, 5'd13, 32'h0000_007F), 1'b0, 32'd5);

      // Bubble discards the held load without counting it.
      apply("bubble",  ST_BUBBLE, mk(32'h1FC, 3'b010, 1'b1, 1'b1, 5'd20, 32'h0, 32'hFFFF_0000),
            70'd0, 1'b0, 32'd5);
      apply("lw_pre",  ST_RUN, mk(32'h200, 3'b010, 1'b1, 1'b1, 5'd14, 32'h0000_9000, 32'hA5A5_A5A5),
            wb(32'h200, 1'b1, 5'd14, 32'hA5A5_A5A5), 1'b0, 32'd5);
      for (int i = 0; i < 3; i++) begin
         apply("hold", ST_HOLD, mk(32'h300 + 32'(i), 3'b000, 1'b1, 1'b0, 5'd21, 32'h3, 32'h0),
               wb(32'h200, 1'b1, 5'd14, 32'hA5A5_A5A5), 1'b0, 32'd5);
      end
      apply("release", ST_RUN, mk(32'h204, 3'b000, 1'b0, 1'b1, 5'd1, 32'h0000_ABCD, 32'h0),
            wb(32'h204, 1'b1, 5'd1, 32'h0000_ABCD), 1'b0, 32'd6);

      // Preload the counter close to its limit, then stream aligned loads through the wrap.
      force dut.ld_count_r = 32'hFFFF_FFFE;
      #1;
      release dut.ld_count_r;
      apply("wrap0", ST_RUN, mk(32'h400, 3'b010, 1'b1, 1'b1, 5'd2, 32'h0, 32'h0000_0001),
            wb(32'h400, 1'b1, 5'd2, 32'h0000_0001), 1'b0, 32'hFFFF_FFFE);
      apply("wrap1", ST_RUN, mk(32'h404, 3'b010, 1'b1, 1'b1, 5'd2, 32'h4, 32'h0000_0002),
            wb(32'h404, 1'b1, 5'd2, 32'h0000_0002), 1'b0, 32'hFFFF_FFFF);
      apply("wrap2", ST_RUN, mk(32'h408, 3'b010, 1'b1, 1'b1, 5'd2, 32'h8, 32'h0000_0003),
            wb(32'h408, 1'b1, 5'd2, 32'h0000_0003), 1'b0, 32'd0);
      apply("wrap3", ST_RUN, mk(32'h40C, 3'b010, 1'b1, 1'b1, 5'd2, 32'hC, 32'h0000_0004),
            wb(32'h40C, 1'b1, 5'd2, 32'h0000_0004), 1'b0, 32'd1);

      // Reset in the middle of the stream drops the held load uncounted.
      rst_n = 1'b0;
      apply("midrst", ST_RUN, mk(32'h410, 3'b010, 1'b1, 1'b1, 5'd2, 32'h10, 32'h0000_0005),
            70'd0, 1'b0, 32'd0);
      rst_n = 1'b1;
      apply("postrst", ST_RUN, mk(32'h500, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0),
            wb(32'h500, 1'b0, 5'd0, 32'h0), 1'b0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
